// File: rtl/int_to_float_converter.sv
// rtl/int_to_float_converter.sv - iterative 32-bit integer to IEEE-754 single converter
// Optional feature macro: FCVT_ROUND_NEAREST_EN (round-to-nearest-even; truncation when undefined)
module int_to_float_converter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_operand,
  input  logic        is_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        inexact
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_sign;
  logic [31:0] r_mant;
  logic [8:0]  r_exp;
  logic [31:0] r_result;
  logic        r_inexact;

  logic        w_accept;
  logic        w_sign_in;
  logic [31:0] w_mag_in;
  logic        w_mag_zero;
  logic        w_guard;
  logic        w_sticky;
  logic        w_inc;
  logic [23:0] w_frac_sum;
  logic        w_carry;
  logic [7:0]  w_exp_rnd;
  logic [22:0] w_frac_rnd;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign inexact   = r_inexact;

  assign w_accept   = in_valid & in_ready;
  assign w_sign_in  = ~is_unsigned & int_operand[31];
  assign w_mag_in   = w_sign_in ? (~int_operand + 32'd1) : int_operand;
  assign w_mag_zero = (w_mag_in == 32'd0);

  // Bits below the 24-bit significand decide rounding and inexact.
  assign w_guard  = r_mant[7];
  assign w_sticky = |r_mant[6:0];
`ifdef FCVT_ROUND_NEAREST_EN
  assign w_inc = w_guard & (w_sticky | r_mant[8]);
`else
  assign w_inc = 1'b0;
`endif

  // A carry out of the fraction means the significand rolled to 2.0: bump exponent.
  assign w_frac_sum = {1'b0, r_mant[30:8]} + {23'd0, w_inc};
  assign w_carry    = w_frac_sum[23];
  assign w_exp_rnd  = r_exp[7:0] + {7'd0, w_carry};
  assign w_frac_rnd = w_carry ? 23'd0 : w_frac_sum[22:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: zero skips straight to DONE, others normalise one bit per cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_mag_zero ? ST_DONE : ST_NORM;
        end
      end
      ST_NORM: begin
        if (r_mant[31]) begin
          w_next_state = ST_ROUND;
        end
      end
      ST_ROUND: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, shift during NORM, pack the result in ROUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign    <= 1'b0;
      r_mant    <= 32'd0;
      r_exp     <= 9'd0;
      r_result  <= 32'd0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sign <= w_sign_in;
            r_mant <= w_mag_in;
            r_exp  <= 9'd158;
            if (w_mag_zero) begin
              r_result  <= 32'd0;
              r_inexact <= 1'b0;
            end
          end
        end
        ST_NORM: begin
          if (!r_mant[31]) begin
            r_mant <= {r_mant[30:0], 1'b0};
            r_exp  <= r_exp - 9'd1;
          end
        end
        ST_ROUND: begin
          r_result  <= {r_sign, w_exp_rnd, w_frac_rnd};
          r_inexact <= w_guard | w_sticky;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float_converter.sv
// tb/tb_int_to_float_converter.sv - self-checking bench for int_to_float_converter
module tb_int_to_float_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_operand;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        inexact;

  int checks;
  int failures;

  int_to_float_converter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .int_operand (int_operand),
    .is_unsigned (is_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .inexact     (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value-level conversion using integer arithmetic on the magnitude.
  function automatic void ref_conv(input logic [31:0] op, input logic uns,
                                   output logic [31:0] res, output logic inx, output int lat);
    longint m;
    longint q;
    longint rem;
    longint half;
    bit     s;
    int     p;
    int     e;
    int     sh;
    logic [63:0] qv;
    logic [31:0] ev;
    s = !uns && op[31];
    m = longint'({32'd0, op});
    if (s) m = 64'h1_0000_0000 - m;
    if (m == 0) begin
      res = 32'd0;
      inx = 1'b0;
      lat = 0;
      return;
    end
    p = 0;
    for (int i = 0; i < 33; i++) if (((m >> i) & 1) == 1) p = i;
    e = 127 + p;
    if (p <= 23) begin
      q   = m << (23 - p);
      inx = 1'b0;
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
`ifdef FCVT_ROUND_NEAREST_EN
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
`endif
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    qv  = q;
    ev  = e;
    res = {s, ev[7:0], qv[22:0]};
    lat = (31 - p) + 2;
  endfunction

  // Run one conversion; compare result, inexact and latency against the model.
  task automatic convert(input string tag, input logic [31:0] op, input logic uns);
    logic [31:0] exp_res;
    logic        exp_inx;
    int          exp_lat;
    int          lat;
    int          w;
    ref_conv(op, uns, exp_res, exp_inx, exp_lat);
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    int_operand = op;
    is_unsigned = uns;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    int_operand = $urandom;
    is_unsigned = $urandom_range(0, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_inexact"}, {31'd0, inexact}, {31'd0, exp_inx});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_res;
    logic        exp_inx;
    int          exp_lat;
    int          lat;
    int          stray;
    logic [31:0] op;
    logic [31:0] held;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    int_operand = 32'd0;
    is_unsigned = 1'b0;
    out_ready   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_inexact", {31'd0, inexact}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with literal expectations.
    convert("s_one", 32'h00000001, 1'b0);
    check("s_one_lit", result, 32'h3F800000);
    convert("s_m1", 32'hFFFFFFFF, 1'b0);
    check("s_m1_lit", result, 32'hBF800000);
    convert("s_min", 32'h80000000, 1'b0);
    check("s_min_lit", result, 32'hCF000000);
    convert("s_zero", 32'h00000000, 1'b0);
    check("s_zero_lit", result, 32'h00000000);
    convert("u_zero", 32'h00000000, 1'b1);
    convert("u_max", 32'hFFFFFFFF, 1'b1);
`ifdef FCVT_ROUND_NEAREST_EN
    check("u_max_lit", result, 32'h4F800000);
`else
    check("u_max_lit", result, 32'h4F7FFFFF);
`endif
    check("u_max_inx", {31'd0, inexact}, 32'd1);
    convert("tie3", 32'h01000003, 1'b0);
`ifdef FCVT_ROUND_NEAREST_EN
    check("tie3_lit", result, 32'h4B800002);
`else
    check("tie3_lit", result, 32'h4B800001);
`endif
    convert("tie1", 32'h01000001, 1'b0);
    check("tie1_lit", result, 32'h4B800000);
    convert("u_bit31", 32'h80000001, 1'b1);

    // Randomised operands with varied leading-zero counts.
    for (int i = 0; i < 40; i++) begin
      op = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) op = ~op;
      convert("rand", op, $urandom_range(0, 1));
    end

    // Backpressure: result held, no second accept while DONE.
    op = 32'h00123457;
    ref_conv(op, 1'b0, exp_res, exp_inx, exp_lat);
    in_valid = 1'b1; int_operand = op; is_unsigned = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_latency", lat, exp_lat);
    held = result;
    check("bp_result", held, exp_res);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid    = ~in_valid;
      int_operand = $urandom;
      is_unsigned = $urandom_range(0, 1);
      @(posedge clk); #1;
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stray++;
    end
    check("bp_stable", stray, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_released_valid", {31'd0, out_valid}, 32'd0);
    check("bp_released_ready", {31'd0, in_ready}, 32'd1);

    // Reset during NORM aborts the conversion.
    in_valid = 1'b1; int_operand = 32'h00000001; is_unsigned = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_inexact", {31'd0, inexact}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stray++;
    end
    check("mid_rst_no_stale", stray, 0);
    convert("post_rst", 32'hFFFF8001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
